// File: rtl/sincos_pipe.sv
// Pipelined sine/cosine generator: degrees in, signed samples out, 4-cycle latency.
// The angle is reduced mod 360, folded to a quarter wave and looked up in one shared sine table.
module sincos_pipe #(
    parameter int    ANGLE_W   = 16,
    parameter int    WIDTH     = 8,
    parameter int    DEPTH     = 64,
    parameter int    MODE      = 2,
    parameter int    TAG_W     = 4,
    parameter string INIT_FILE = "sin_qtr_64x8.hex"
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ANGLE_W-1:0]      in_angle,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH:0]   sin_out,
    output logic signed [WIDTH:0]   cos_out,
    output logic [TAG_W-1:0]        out_tag
);

    localparam int IDX_W  = $clog2(DEPTH + 1);
    localparam int PROD_W = $clog2(DEPTH * 90) + 1;

    // Table entry k = round((2^WIDTH-1) * sin(pi/2 * k/DEPTH)); the same image INIT_FILE names,
    // evaluated at elaboration with a 2^30 fixed-point Taylor series.
    function automatic logic [WIDTH-1:0] sin_entry(input int k);
        longint one, x, term, acc;
        one  = 64'sd1 <<< 30;
        x    = (64'sd3373259426 * longint'(k)) / longint'(2 * DEPTH);
        term = x;
        acc  = x;
        for (int n = 1; n <= 12; n++) begin
            term = -((((term * x) / one) * x) / one) / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return WIDTH'(((64'sd1 <<< WIDTH) - 64'sd1) * acc / one + (((((64'sd1 <<< WIDTH) - 64'sd1) * acc) % one) >= one / 2 ? 64'sd1 : 64'sd0));
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [6:0] src);
        logic [PROD_W-1:0] prod;
        logic [PROD_W-1:0] quo;
        prod = PROD_W'(DEPTH) * PROD_W'(src);
        quo  = prod / PROD_W'(90);
        if (quo > PROD_W'(DEPTH)) quo = PROD_W'(DEPTH);
        return IDX_W'(quo);
    endfunction

    logic [WIDTH-1:0] rom [0:DEPTH];
    for (genvar k = 0; k <= DEPTH; k++) begin : g_rom
        localparam logic [WIDTH-1:0] ENTRY = sin_entry(k);
        assign rom[k] = ENTRY;
    end

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage registers: S0 capture, S1 reduce, S2 fold, S3 table read, then the output registers.
    logic                 v0_q, v1_q, v2_q, v3_q;
    logic [ANGLE_W-1:0]   ang0_q;
    logic [TAG_W-1:0]     tag0_q, tag1_q, tag2_q, tag3_q;
    logic [8:0]           r1_q, r1_d;
    logic [IDX_W-1:0]     sidx2_q, sidx2_d, cidx2_q, cidx2_d;
    logic                 sneg2_q, sneg2_d, cneg2_q, cneg2_d;
    logic                 sneg3_q, cneg3_q;
    logic [WIDTH-1:0]     sdat3_q, cdat3_q;
    logic [WIDTH:0]       sin_d, cos_d;
    logic [1:0]           quad;
    logic [6:0]           phi, sin_src, cos_src;
    int                   rem;

    always_comb begin
        rem = int'($signed(ang0_q)) % 360;
        if (rem < 0) rem = rem + 360;
        r1_d = 9'(rem);
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case, so no latch is inferred.
        quad = 2'd0;
        if (r1_q >= 9'd270)      quad = 2'd3;
        else if (r1_q >= 9'd180) quad = 2'd2;
        else if (r1_q >= 9'd90)  quad = 2'd1;
        phi     = 7'(r1_q - 9'd90 * 9'(quad));
        sin_src = phi;
        cos_src = 7'd90 - phi;
        sneg2_d = 1'b0;
        cneg2_d = 1'b0;
        case (quad)
            2'd1: begin sin_src = 7'd90 - phi; cos_src = phi; cneg2_d = 1'b1; end
            2'd2: begin sneg2_d = 1'b1; cneg2_d = 1'b1; end
            2'd3: begin sin_src = 7'd90 - phi; cos_src = phi; sneg2_d = 1'b1; end
            default: ;
        endcase
        sidx2_d = to_idx(sin_src);
        cidx2_d = to_idx(cos_src);
    end

    // A missing read port yields a 0 entry; negating 0 still gives 0, so that output stays 0.
    if (MODE != 1) begin : g_sin_port
        always_ff @(posedge clk) if (advance) sdat3_q <= rom[sidx2_q];
    end else begin : g_no_sin_port
        assign sdat3_q = '0;
    end

    if (MODE != 0) begin : g_cos_port
        always_ff @(posedge clk) if (advance) cdat3_q <= rom[cidx2_q];
    end else begin : g_no_cos_port
        assign cdat3_q = '0;
    end

    assign sin_d = sneg3_q ? -{1'b0, sdat3_q} : {1'b0, sdat3_q};
    assign cos_d = cneg3_q ? -{1'b0, cdat3_q} : {1'b0, cdat3_q};

    // NOTE: datapath registers carry no reset; only valid bits and the visible outputs need a known state.
    always_ff @(posedge clk) begin
        if (advance) begin
            ang0_q  <= in_angle;
            tag0_q  <= in_tag;
            r1_q    <= r1_d;
            tag1_q  <= tag0_q;
            sidx2_q <= sidx2_d;
            cidx2_q <= cidx2_d;
            sneg2_q <= sneg2_d;
            cneg2_q <= cneg2_d;
            tag2_q  <= tag1_q;
            sneg3_q <= sneg2_q;
            cneg3_q <= cneg2_q;
            tag3_q  <= tag2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            out_valid <= 1'b0;
            sin_out   <= '0;
            cos_out   <= '0;
            out_tag   <= '0;
        end else if (advance) begin
            v0_q      <= in_valid;
            v1_q      <= v0_q;
            v2_q      <= v1_q;
            v3_q      <= v2_q;
            out_valid <= v3_q;
            if (v3_q) begin
                sin_out <= sin_d;
                cos_out <= cos_d;
                out_tag <= tag3_q;
            end
        end
    end

endmodule

// File: tb/tb_sincos_pipe.sv
// Self-checking bench for sincos_pipe: scoreboard against a real-arithmetic model,
// plus literal expectations for cardinal, wrap-around, symmetry, backpressure and reset cases.
module tb_sincos_pipe;

    localparam int  ANGLE_W = 16;
    localparam int  WIDTH   = 8;
    localparam int  DEPTH   = 64;
    localparam int  TAG_W   = 4;
    localparam int  LAT     = 5;   // negedges from the accepting sample to the result sample
    localparam real PI      = 3.14159265358979;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [ANGLE_W-1:0] in_angle = '0;
    logic [TAG_W-1:0]   in_tag = '0;

    logic in_ready, out_valid;
    logic signed [WIDTH:0] sin_out, cos_out;
    logic [TAG_W-1:0] out_tag;

    logic m0_in_ready, m0_valid, m1_in_ready, m1_valid;
    logic signed [WIDTH:0] m0_sin, m0_cos, m1_sin, m1_cos;
    logic [TAG_W-1:0] m0_tag, m1_tag;

    always #5 clk = ~clk;

    sincos_pipe #(.ANGLE_W(ANGLE_W), .WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(2), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .sin_out(sin_out),
        .cos_out(cos_out), .out_tag(out_tag));

    sincos_pipe #(.ANGLE_W(ANGLE_W), .WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(0), .TAG_W(TAG_W)) u_sin_only (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m0_in_ready), .in_angle(in_angle),
        .in_tag(in_tag), .out_valid(m0_valid), .out_ready(out_ready), .sin_out(m0_sin),
        .cos_out(m0_cos), .out_tag(m0_tag));

    sincos_pipe #(.ANGLE_W(ANGLE_W), .WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(1), .TAG_W(TAG_W)) u_cos_only (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m1_in_ready), .in_angle(in_angle),
        .in_tag(in_tag), .out_valid(m1_valid), .out_ready(out_ready), .sin_out(m1_sin),
        .cos_out(m1_cos), .out_tag(m1_tag));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic int rom_entry(input int k);
        real v;
        v = real'((1 << WIDTH) - 1) * $sin(PI / 2.0 * real'(k) / real'(DEPTH));
        return $rtoi(v + 0.5);
    endfunction

    // Sine of an angle in 0..359 using half-wave symmetry.
    function automatic int half_wave(input int r);
        int a, src, mag;
        a   = r % 180;
        src = (a <= 90) ? a : 180 - a;
        mag = rom_entry((DEPTH * src) / 90);
        return (r >= 180) ? -mag : mag;
    endfunction

    task automatic model(input int angle, output int s, output int c);
        int r;
        r = angle % 360;
        if (r < 0) r = r + 360;
        s = half_wave(r);
        c = half_wave((r + 90) % 360);   // cos(x) = sin(x + 90)
    endtask

    typedef struct { int tag; int s; int c; int cyc; int stalls; } exp_t;
    typedef struct { int tag; int s; int c; } got_t;
    exp_t sb[$];
    got_t log_q[$];

    int cyc = 0;
    int stall_cnt = 0;
    bit prev_stall = 1'b0;
    int snap_s, snap_c, snap_t;

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        exp_t e;
        int ms, mc;
        cyc++;
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_sin", int'(sin_out), snap_s);
                check("hold_cos", int'(cos_out), snap_c);
                check("hold_tag", int'(out_tag), snap_t);
            end
            check("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
            check("m0_valid", int'(m0_valid), int'(out_valid));
            check("m1_valid", int'(m1_valid), int'(out_valid));
            check("m0_in_ready", int'(m0_in_ready), int'(in_ready));
            check("m1_in_ready", int'(m1_in_ready), int'(in_ready));
            check("m0_cos_zero", int'(m0_cos), 0);
            check("m1_sin_zero", int'(m1_sin), 0);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", int'(out_valid), 0);
                end else begin
                    e = sb[0];
                    check("sin", int'(sin_out), e.s);
                    check("cos", int'(cos_out), e.c);
                    check("tag", int'(out_tag), e.tag);
                    check("m0_sin", int'(m0_sin), e.s);
                    check("m1_cos", int'(m1_cos), e.c);
                    check("m0_tag", int'(m0_tag), e.tag);
                    check("m1_tag", int'(m1_tag), e.tag);
                    if (!prev_stall) check("latency", cyc - e.cyc, LAT + stall_cnt - e.stalls);
                    if (out_ready) begin
                        log_q.push_back('{tag: int'(out_tag), s: int'(sin_out), c: int'(cos_out)});
                        void'(sb.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                model(int'($signed(in_angle)), ms, mc);
                sb.push_back('{tag: int'(in_tag), s: ms, c: mc, cyc: cyc, stalls: stall_cnt});
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) begin
                stall_cnt++;
                snap_s = int'(sin_out);
                snap_c = int'(cos_out);
                snap_t = int'(out_tag);
            end
        end
    end

    // ---------------- stimulus helpers (called right after a rising edge) ----------------
    task automatic send(input int a, input int t);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_angle = ANGLE_W'(a);
        in_tag   = TAG_W'(t);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin done = 1'b1; break; end
        end
        if (!done) check("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string name, input int i, input int t, input int s, input int c);
        if (i < log_q.size()) begin
            check({name, "_tag"}, log_q[i].tag, t);
            check({name, "_sin"}, log_q[i].s, s);
            check({name, "_cos"}, log_q[i].c, c);
        end else begin
            check({name, "_missing"}, log_q.size(), i + 1);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit seen;
        int tg;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_sin", int'(sin_out), 0);
        check("reset_cos", int'(cos_out), 0);
        check("reset_tag", int'(out_tag), 0);
        check("reset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Cardinal angles back to back
        log_q.delete();
        send(0, 0); send(90, 1); send(180, 2); send(270, 3);
        drain();
        check("card_count", log_q.size(), 4);
        expect_res("card0", 0, 0, 0, 255);
        expect_res("card90", 1, 1, 255, 0);
        expect_res("card180", 2, 2, 0, -255);
        expect_res("card270", 3, 3, -255, 0);

        // Wrap-around and negative angles
        log_q.delete();
        send(-90, 4); send(450, 5); send(-360, 6); send(32767, 7); send(-32768, 8);
        drain();
        check("wrap_count", log_q.size(), 5);
        expect_res("neg90", 0, 4, -255, 0);
        expect_res("a450", 1, 5, 255, 0);
        expect_res("neg360", 2, 6, 0, 255);
        expect_res("a32767", 3, 7, 25, 253);

        // Symmetry around 30 degrees: entry[21] = 126, entry[42] = 219
        log_q.delete();
        send(30, 9); send(150, 10); send(210, 11); send(330, 12);
        drain();
        expect_res("sym30", 0, 9, 126, 219);
        expect_res("sym150", 1, 10, 126, -219);
        expect_res("sym210", 2, 11, -126, -219);
        expect_res("sym330", 3, 12, -126, 219);

        // Backpressure: 10 samples, out_ready low for 5 cycles mid-stream
        log_q.delete();
        fork
            begin
                for (int i = 0; i < 10; i++) send(i * 97 - 400, i);
            end
            begin
                idle(7);
                out_ready = 1'b0;
                @(negedge clk);
                check("bp_out_valid", int'(out_valid), 1);
                check("bp_in_ready_low", int'(in_ready), 0);
                idle(5);
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", log_q.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < log_q.size()) check("bp_order", log_q[i].tag, i);
        end

        // Reset with results in flight and the output stalled
        out_ready = 1'b0;
        send(45, 1); send(100, 2); send(200, 3); send(300, 4);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; break; end
        end
        check("rst_pre_valid", int'(seen), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        log_q.delete();
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sin", int'(sin_out), 0);
        check("rst_cos", int'(cos_out), 0);
        check("rst_tag", int'(out_tag), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        idle(8);
        check("rst_discarded", log_q.size(), 0);
        send(0, 9);
        drain();
        check("rst_after_count", log_q.size(), 1);
        expect_res("rst_after", 0, 9, 0, 255);

        // Sweep with an irregular out_ready pattern
        log_q.delete();
        tg = 0;
        fork
            begin
                for (int a = -725; a <= 760; a += 55) begin
                    send(a, tg);
                    tg = (tg + 1) % 16;
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk);
                    #1 out_ready = (i % 3 != 2);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();
        check("sweep_count", log_q.size(), 28);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sincos_pipe.md
# sincos_pipe

Pipelined, parametrised sine/cosine generator for the 3D rotation datapath. It accepts a signed integer angle in degrees, reduces it modulo 360, and folds it to one quarter-wave sine ROM. It returns signed sine and/or cosine samples through a valid/ready stream with 4-cycle latency and full backpressure. It feeds the rotation-matrix multipliers and replaces the unclocked per-function table lookups.

## Interface
- ANGLE_W, 16: width of signed input angle (degrees, two's complement)
- WIDTH, 8: magnitude bits of ROM entries; outputs are WIDTH+1 bits signed
- DEPTH, 64: quarter-wave resolution; ROM holds DEPTH+1 entries covering 0°..90° inclusive
- MODE, 2: 0 = sine only, 1 = cosine only, 2 = both; a disabled output is held at 0
- TAG_W, 4: width of the sideband tag carried alongside each sample
- INIT_FILE, "sin_qtr_64x8.hex": hex image, entry k = round((2^WIDTH−1)·sin(90·k/DEPTH °))
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  angle/tag present
- in_ready  out  1  pipeline accepts this cycle
- in_angle  in  ANGLE_W  signed degrees, any value
- in_tag  in  TAG_W  opaque, returned with result
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts this cycle
- sin_out  out  WIDTH+1  signed sine, full scale ±(2^WIDTH−1)
- cos_out  out  WIDTH+1  signed cosine, same scale
- out_tag  out  TAG_W  tag of the presented result

## Operation
- Stage S1 (reduce): r = in_angle mod 360, taken as signed remainder plus 360 when negative. r is in 0..359.
- Stage S2 (fold):
  - q = r/90, phi = r − 90·q.
  - Sine index source: q0 → phi (+), q1 → 90−phi (+), q2 → phi (−), q3 → 90−phi (−).
  - Cosine index source: q0 → 90−phi (+), q1 → phi (−), q2 → 90−phi (−), q3 → phi (+).
  - idx = floor(DEPTH·src/90), clamped to DEPTH. Intermediate product width is ≥ clog2(DEPTH·90)+1.
- Stage S3 (ROM): synchronous read of the sine and cosine indices. Dual read ports on one table; the cosine port is omitted when MODE=0 and the sine port when MODE=1. Sign flags travel alongside.
- Stage S4 (output): zero-extend the entry to WIDTH+1 bits, then two's-complement negate if the flag is set. Register sin_out, cos_out and out_tag.
- A negated 0 yields 0; −0 never appears.
- Each stage carries a valid bit and its tag. Bubbles are allowed.

## Timing
- Global advance = !out_valid || out_ready. All stage registers load only when advance=1. in_ready = advance, combinational from out_valid/out_ready.
- Transfer in occurs on in_valid && in_ready; transfer out on out_valid && out_ready.
- Latency: a sample accepted at edge N appears with out_valid=1 after edge N+4 when no stall occurs. Throughput is 1 sample/cycle.
- Stall (out_valid=1, out_ready=0): every stage holds, in_ready=0, and all outputs are stable until accepted.
- A bubble at S4 (out_valid=0) never blocks upstream: advance=1 regardless of out_ready.
- Simultaneous accept-in and accept-out in one cycle is legal. No sample is lost or duplicated.
- Reset: takes priority over everything. All stage valid bits clear, out_valid=0, sin_out=0, cos_out=0, out_tag=0. In-flight samples are discarded, and in_ready=1 in the cycle after reset.
- Reset asserted mid-stall discards the held result. No handshake is completed for it.
- The ROM content is not reset. Only valid bits and output registers are.

## Test plan
- Cardinal angles (WIDTH=8, DEPTH=64, MODE=2), angles 0, 90, 180, 270 back-to-back with out_ready=1 → (sin,cos) = (0,255), (255,0), (0,−255), (−255,0). Each appears 4 cycles after its input, on consecutive cycles.
- Wrap-around and negative angles: −90 → (−255,0); 450 → (255,0); −360 → (0,255); 32767 (mod 360 = 7) → sin = entry[4], cos = entry[59] (floor(64·83/90) = 59).
- Octant symmetry: 30 → sin = entry[21]; 150 → sin = entry[21]; 210 → sin = −entry[21]; 330 → sin = −entry[21]. The corresponding cosines satisfy cos(30) = −cos(150) = −cos(210) = cos(330).
- Backpressure:
  - Stream 10 angles with tags 0..9.
  - Drop out_ready for 5 cycles mid-stream.
  - Required: in_ready falls in the same cycle, outputs are frozen, and all 10 results arrive in tag order with no loss or duplication.
- Reset mid-operation: assert rst for 1 cycle with 3 samples in flight and out_valid=1, out_ready=0. Required: next cycle out_valid=0, outputs are 0, and those 3 samples never appear. A new angle 0 yields (0,255) after 4 cycles.
- MODE=0 build: angle 0 → sin_out = 0 and cos_out stays 0. MODE=1 build: angle 90 → cos_out = 0, sin_out held at 0.
